// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    FLUSH = 2'd3
  } ifu_state_t;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/ifu_out_reg.sv
// One-entry fetch output register; priority clear > load > consume.
// if_misalign exists only when IFU_MISALIGN_TRAP_EN is defined.
module ifu_out_reg #(
  parameter int unsigned PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            consume,
  input  logic            clear,
  input  logic [PC_W-1:0] load_pc,
  input  logic [PC_W-1:0] load_instr,
`ifdef IFU_MISALIGN_TRAP_EN
  input  logic            load_misalign,
  output logic            if_misalign,
`endif
  output logic            if_valid,
  output logic [PC_W-1:0] if_pc,
  output logic [PC_W-1:0] if_instr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_instr <= '0;
    end else if (clear) begin
      if_valid <= 1'b0;
    end else if (load) begin
      if_valid <= 1'b1;
      if_pc    <= load_pc;
      if_instr <= load_instr;
    end else if (consume) begin
      if_valid <= 1'b0;
    end
  end

`ifdef IFU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_misalign <= 1'b0;
    end else if (clear) begin
      if_misalign <= 1'b0;
    end else if (load) begin
      if_misalign <= load_misalign;
    end else if (consume) begin
      if_misalign <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, one imem request at a time, drops stale responses.
// Optional misaligned-target trap reporting via IFU_MISALIGN_TRAP_EN.
module ifu_fetch_ctrl
  import ifu_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_take,
  input  logic [PC_W-1:0] branch_pc,
  input  logic            trap_take,
  input  logic [PC_W-1:0] trap_pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [PC_W-1:0] imem_rdata,
  output logic            if_valid,
  output logic [PC_W-1:0] if_pc,
  output logic [PC_W-1:0] if_instr
`ifdef IFU_MISALIGN_TRAP_EN
  ,
  output logic            if_misalign
`endif
);

  ifu_state_t      state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic            req_hold_q, req_hold_d;

  logic            redirect;
  logic [PC_W-1:0] redir_sel;
  logic [PC_W-1:0] target;
  logic            bad_target;
  logic            accept;
  logic            resp_load;
  logic            consume;
  logic            out_load;
  logic            out_clear;
  logic [PC_W-1:0] out_pc;
  logic [PC_W-1:0] out_instr;

  assign redirect  = trap_take | branch_take;
  assign redir_sel = trap_take ? trap_pc : branch_pc;

`ifdef IFU_MISALIGN_TRAP_EN
  logic halt_q, halt_d;

  assign target     = redir_sel;
  assign bad_target = redirect & (|redir_sel[1:0]);
`else
  assign target     = redir_sel & ~{{(PC_W-2){1'b0}}, 2'b11};
  assign bad_target = 1'b0;
`endif

  // Once raised, the request is held until granted regardless of back-pressure.
  assign imem_req  = (state_q == REQ) & (req_hold_q | ~if_valid | ~stall);
  assign imem_addr = fetch_pc_q;
  assign accept    = imem_req & imem_gnt;
  assign resp_load = (state_q == WAIT) & imem_rvalid & ~redirect;
  assign consume   = if_valid & ~stall;

  assign out_clear = redirect & ~bad_target;
  assign out_load  = resp_load | bad_target;
  assign out_pc    = bad_target ? target : fetch_pc_q;
  assign out_instr = bad_target ? '0 : imem_rdata;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_hold_d = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
    halt_d     = halt_q;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef IFU_MISALIGN_TRAP_EN
        if (!halt_q) state_d = REQ;
`else
        state_d = REQ;
`endif
      end
      REQ: begin
        if (accept) state_d = WAIT;
        else        req_hold_d = imem_req;
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d    = REQ;
          fetch_pc_d = fetch_pc_q + PC_W'(PC_STEP);
        end
      end
      FLUSH: begin
        if (imem_rvalid) state_d = REQ;
      end
    endcase

    if (redirect) begin
      fetch_pc_d = target;
      unique case (state_q)
        IDLE:  state_d = REQ;
        REQ:   state_d = accept ? FLUSH : REQ;
        WAIT:  state_d = imem_rvalid ? REQ : FLUSH;
        // A response arriving with the redirect is the one being flushed.
        FLUSH: state_d = imem_rvalid ? REQ : FLUSH;
      endcase
`ifdef IFU_MISALIGN_TRAP_EN
      if (bad_target) begin
        state_d    = IDLE;
        req_hold_d = 1'b0;
        halt_d     = 1'b1;
      end else begin
        halt_d     = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_hold_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_hold_q <= req_hold_d;
    end
  end

`ifdef IFU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) halt_q <= 1'b0;
    else     halt_q <= halt_d;
  end
`endif

  ifu_out_reg #(
    .PC_W (PC_W)
  ) u_out_reg (
    .clk           (clk),
    .rst           (rst),
    .load          (out_load),
    .consume       (consume),
    .clear         (out_clear),
    .load_pc       (out_pc),
    .load_instr    (out_instr),
`ifdef IFU_MISALIGN_TRAP_EN
    .load_misalign (bad_target),
    .if_misalign   (if_misalign),
`endif
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr)
  );

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Randomized bench for ifu_fetch_ctrl with a transaction-level fetch model and imem responder.
module tb_ifu_fetch_ctrl;

  localparam int unsigned PC_W   = 32;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
`ifdef IFU_MISALIGN_TRAP_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, branch_take, trap_take;
  logic [31:0] branch_pc, trap_pc;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc, if_instr;
`ifdef IFU_MISALIGN_TRAP_EN
  logic        if_misalign;
`endif

  always #5 clk = ~clk;

  ifu_fetch_ctrl #(
    .PC_W     (PC_W),
    .RESET_PC (RST_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .branch_take (branch_take),
    .branch_pc   (branch_pc),
    .trap_take   (trap_take),
    .trap_pc     (trap_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr)
`ifdef IFU_MISALIGN_TRAP_EN
    ,
    .if_misalign (if_misalign)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return ~a ^ 32'h1357_9BDF;
  endfunction

  // Model: next expected fetch address and the decode-side register.
  logic [31:0] m_pc = RST_PC;
  bit          m_valid = 1'b0;
  logic [31:0] m_if_pc, m_if_instr;
  bit          m_mis = 1'b0;
  bit          m_halt = 1'b0;

  // Memory responder: at most one transaction, tagged stale once a redirect overtakes it.
  bit          mem_busy = 1'b0;
  bit          mem_stale = 1'b0;
  logic [31:0] mem_addr;
  int          mem_cnt = 0;

  bit          prev_pending = 1'b0;
  bit          prev_redir = 1'b0;
  logic [31:0] prev_addr;
  int          idle_cnt = 0;
  int          n_gnt = 0;
  int          n_load = 0;
  logic [31:0] last_gnt_addr, last_load_pc;
  bit          rv_redir_hit = 1'b0;
  logic [31:0] load_log[$];
  logic [31:0] gnt_log[$];

  bit          c_stall = 1'b0, c_br = 1'b0, c_tr = 1'b0, c_on_rvalid = 1'b0;
  logic [31:0] c_bpc = '0, c_tpc = '0;
  int          gnt_prob = 100, lat_min = 1, lat_max = 1;

  task automatic step();
    bit          rv, br_e, tr_e, req, gnt, redir, mis, ld;
    logic [31:0] addr, tgt, ld_pc;
    @(negedge clk);
    rv   = mem_busy && (mem_cnt == 0);
    br_e = c_br && (!c_on_rvalid || rv);
    tr_e = c_tr && (!c_on_rvalid || rv);
    imem_rvalid = rv;
    imem_rdata  = rv ? instr_of(mem_addr) : $urandom();
    stall       = c_stall;
    branch_take = br_e;
    branch_pc   = c_bpc;
    trap_take   = tr_e;
    trap_pc     = c_tpc;
    imem_gnt    = 1'b0;
    #1;
    req  = imem_req;
    addr = imem_addr;
    if (req) begin
      chk("req_addr", addr, m_pc);
      chk1("one_outstanding", mem_busy && !mem_stale, 1'b0);
      chk1("req_while_halted", m_halt, 1'b0);
    end
    if (prev_pending && !prev_redir) begin
      chk1("req_hold", req, 1'b1);
      chk("req_hold_addr", addr, prev_addr);
    end
    if (req && !prev_pending) chk1("req_start_when_full", m_valid && c_stall, 1'b0);
    if (!req && !mem_busy && !m_halt && !(m_valid && c_stall)) idle_cnt++;
    else idle_cnt = 0;
    chk1("req_liveness", idle_cnt > 2, 1'b0);
    if (idle_cnt > 2) idle_cnt = 0;

    gnt = req && !mem_busy && ($urandom_range(0, 99) < gnt_prob);
    imem_gnt = gnt;

    redir = br_e || tr_e;
    tgt   = tr_e ? c_tpc : c_bpc;
    mis   = 1'b0;
    if (MIS_EN) mis = redir && (tgt[1:0] != 2'b00);
    else tgt[1:0] = 2'b00;
    rv_redir_hit = rv && redir;

    ld    = 1'b0;
    ld_pc = mem_addr;
    if (rv) begin
      mem_busy = 1'b0;
      if (!mem_stale && !redir) ld = 1'b1;
    end else if (mem_busy) begin
      mem_cnt--;
      if (redir) mem_stale = 1'b1;
    end
    if (gnt) begin
      n_gnt++;
      last_gnt_addr = addr;
      gnt_log.push_back(addr);
      mem_busy  = 1'b1;
      mem_addr  = addr;
      mem_stale = redir;
      mem_cnt   = $urandom_range(lat_min, lat_max) - 1;
    end

    if (redir) begin
      m_pc = tgt;
      if (mis) begin
        m_valid = 1'b1; m_if_pc = tgt; m_if_instr = '0; m_mis = 1'b1; m_halt = 1'b1;
      end else begin
        m_valid = 1'b0; m_mis = 1'b0; m_halt = 1'b0;
      end
    end else if (ld) begin
      m_valid = 1'b1; m_if_pc = ld_pc; m_if_instr = instr_of(ld_pc); m_mis = 1'b0;
      m_pc = ld_pc + 32'd4;
      n_load++;
    end else if (m_valid && !c_stall) begin
      m_valid = 1'b0; m_mis = 1'b0;
    end
    prev_pending = req && !gnt;
    prev_redir   = redir;
    prev_addr    = addr;

    @(posedge clk);
    #1;
    chk1("if_valid", if_valid, m_valid);
    if (m_valid) begin
      chk("if_pc", if_pc, m_if_pc);
      chk("if_instr", if_instr, m_if_instr);
    end
`ifdef IFU_MISALIGN_TRAP_EN
    chk1("if_misalign", if_misalign, m_mis);
`endif
    if (ld) begin
      last_load_pc = if_pc;
      load_log.push_back(if_pc);
    end
  endtask

  task automatic wait_gnt(input string name);
    int g0 = n_gnt;
    for (int i = 0; i < 60 && n_gnt == g0; i++) step();
    chk1({name, "_gnt_timeout"}, n_gnt != g0, 1'b1);
  endtask

  task automatic wait_load(input string name);
    int l0 = n_load;
    for (int i = 0; i < 60 && n_load == l0; i++) step();
    chk1({name, "_load_timeout"}, n_load != l0, 1'b1);
  endtask

  task automatic clear_ctl();
    c_stall = 1'b0; c_br = 1'b0; c_tr = 1'b0; c_on_rvalid = 1'b0;
  endtask

  logic [31:0] exp_seq [3];
  int          g0, l0;
  bit          hit;

  initial begin
    exp_seq = '{32'h0000_0100, 32'h0000_0104, 32'h0000_0108};
    rst = 1'b1; stall = 1'b0; branch_take = 1'b0; trap_take = 1'b0;
    branch_pc = '0; trap_pc = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_imem_req", imem_req, 1'b0);
    chk("rst_imem_addr", imem_addr, 32'h0000_0100);
    chk1("rst_if_valid", if_valid, 1'b0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Sequential fetch from RESET_PC with single-cycle grant and response.
    load_log.delete();
    gnt_log.delete();
    repeat (3) wait_load("seq");
    chk("first_imem_addr", (gnt_log.size() > 0) ? gnt_log[0] : 32'hxxxx_xxxx, 32'h0000_0100);
    for (int i = 0; i < 3; i++)
      chk("seq_if_pc", (load_log.size() > i) ? load_log[i] : 32'hxxxx_xxxx, exp_seq[i]);

    // Back-pressure holds the output and suppresses new requests.
    c_stall = 1'b1;
    g0 = n_gnt;
    repeat (5) begin
      step();
      chk1("stall_no_req", imem_req, 1'b0);
      chk("stall_if_pc", if_pc, 32'h0000_0108);
    end
    chk("stall_gnt_count", n_gnt, g0);
    clear_ctl();

    // Branch while waiting for a response: old response flushed, refetch at 0x200.
    lat_min = 3; lat_max = 3;
    wait_gnt("br_wait");
    c_br = 1'b1; c_bpc = 32'h0000_0200;
    step();
    clear_ctl();
    l0 = n_load;
    wait_gnt("br_refetch");
    chk("br_refetch_addr", last_gnt_addr, 32'h0000_0200);
    chk("br_no_old_load", n_load, l0);
    wait_load("br_load");
    chk("br_load_pc", last_load_pc, 32'h0000_0200);

    // Trap has priority over a simultaneous branch.
    lat_min = 1; lat_max = 1;
    c_tr = 1'b1; c_tpc = 32'h0000_0080; c_br = 1'b1; c_bpc = 32'h0000_0200;
    step();
    clear_ctl();
    wait_gnt("trap_prio");
    chk("trap_prio_addr", last_gnt_addr, 32'h0000_0080);

    // Redirect coinciding with a response: the response is never presented.
    c_on_rvalid = 1'b1; c_br = 1'b1; c_bpc = 32'h0000_0300;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step();
      hit = rv_redir_hit;
    end
    clear_ctl();
    chk1("rv_redir_hit", hit, 1'b1);
    chk1("rv_redir_not_presented", if_valid, 1'b0);
    wait_gnt("rv_redir");
    chk("rv_redir_addr", last_gnt_addr, 32'h0000_0300);
    wait_load("rv_redir");
    chk("rv_redir_load_pc", last_load_pc, 32'h0000_0300);

    // PC increment wraps at the top of the address space.
    c_br = 1'b1; c_bpc = 32'hFFFF_FFFC;
    step();
    clear_ctl();
    wait_load("wrap");
    chk("wrap_load_pc", last_load_pc, 32'hFFFF_FFFC);
    wait_gnt("wrap");
    chk("wrap_next_addr", last_gnt_addr, 32'h0000_0000);

`ifdef IFU_MISALIGN_TRAP_EN
    c_br = 1'b1; c_bpc = 32'h0000_0202;
    step();
    clear_ctl();
    c_stall = 1'b1;
    chk1("mis_if_valid", if_valid, 1'b1);
    chk1("mis_flag", if_misalign, 1'b1);
    chk("mis_if_pc", if_pc, 32'h0000_0202);
    chk("mis_if_instr", if_instr, 32'h0);
    g0 = n_gnt;
    repeat (5) step();
    chk("mis_no_fetch", n_gnt, g0);
    clear_ctl();
    c_br = 1'b1; c_bpc = 32'h0000_0400;
    step();
    clear_ctl();
`endif

    // Randomized traffic.
    gnt_prob = 60; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      c_stall     = ($urandom_range(0, 99) < 30);
      c_tr        = ($urandom_range(0, 99) < 3);
      c_br        = ($urandom_range(0, 99) < 7);
      c_on_rvalid = ($urandom_range(0, 99) < 10);
      c_bpc = $urandom_range(0, 4095) & (($urandom_range(0, 3) == 0) ? 32'hFFF : 32'hFFC);
      c_tpc = $urandom_range(0, 4095) & (($urandom_range(0, 3) == 0) ? 32'hFFF : 32'hFFC);
      step();
    end
    chk1("random_made_progress", n_load > 100, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
